// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: data width, register count and x0 address.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_scoreboard.sv
// Busy-bit scoreboard: tracks destinations whose results are still in flight
// and raises stall when decode reads one that has not been written back yet.
module scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG_P = riscv_pkg::NREG,
    parameter int AW_P   = riscv_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW_P-1:0] RS1,
    input  logic [AW_P-1:0] RS2,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic            RegWrite,
    input  logic [AW_P-1:0] WR,
    input  logic            issue,
    input  logic [AW_P-1:0] issue_rd,
    input  logic            issue_wr,
    output logic            stall
);
    localparam logic [AW_P-1:0] ZERO = AW_P'(REG_ZERO);

    logic [NREG_P-1:0] r_busy;
    logic              w_haz1;
    logic              w_haz2;
    logic              w_clr;
    logic              w_set;

    // Hazard on a port unless the producer is writing back this very cycle
    // (the bypass path then delivers the value).
    always_comb begin
        w_haz1 = use_rs1 && (RS1 != ZERO) && r_busy[RS1] && !(RegWrite && (WR == RS1));
        w_haz2 = use_rs2 && (RS2 != ZERO) && r_busy[RS2] && !(RegWrite && (WR == RS2));
        stall  = w_haz1 | w_haz2;
        w_clr  = RegWrite && (WR != ZERO);
        // An issue during stall is illegal and is dropped.
        w_set  = issue && issue_wr && (issue_rd != ZERO) && !stall;
    end

    // Busy update: set is written last so a younger producer wins over a
    // write-back to the same rd on the same edge; reset overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_clr) r_busy[WR]       <= 1'b0;
            if (w_set) r_busy[issue_rd] <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb.sv
// Integer register file with write-to-read bypass and write-back scoreboard.
module regfile_wb
    import riscv_pkg::*;
#(
    parameter int XLEN_P = riscv_pkg::XLEN,
    parameter int NREG_P = riscv_pkg::NREG,
    parameter int AW_P   = riscv_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW_P-1:0]   RS1,
    input  logic [AW_P-1:0]   RS2,
    output logic [XLEN_P-1:0] RD1,
    output logic [XLEN_P-1:0] RD2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              RegWrite,
    input  logic [AW_P-1:0]   WR,
    input  logic [XLEN_P-1:0] WD,
    input  logic              issue,
    input  logic [AW_P-1:0]   issue_rd,
    input  logic              issue_wr,
    output logic              stall
);
    localparam logic [AW_P-1:0] ZERO = AW_P'(REG_ZERO);

    logic [XLEN_P-1:0] r_mem [NREG_P];
    logic              w_we;

    assign w_we = RegWrite && (WR != ZERO);

    // Array write; x0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG_P; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[WR] <= WD;
        end
    end

    // Combinational read: x0 forced to zero, same-cycle write-back bypassed.
    always_comb begin
        RD1 = r_mem[RS1];
        RD2 = r_mem[RS2];
        if (w_we && (WR == RS1)) RD1 = WD;
        if (w_we && (WR == RS2)) RD2 = WD;
        if (RS1 == ZERO) RD1 = '0;
        if (RS2 == ZERO) RD2 = '0;
    end

    scoreboard #(
        .NREG_P (NREG_P),
        .AW_P   (AW_P)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .RS1      (RS1),
        .RS2      (RS2),
        .use_rs1  (use_rs1),
        .use_rs2  (use_rs2),
        .RegWrite (RegWrite),
        .WR       (WR),
        .issue    (issue),
        .issue_rd (issue_rd),
        .issue_wr (issue_wr),
        .stall    (stall)
    );
endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vectors with literal checks, plus a
// reference model compared against the outputs every cycle.
module tb_regfile_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RS1, RS2, WR, issue_rd;
    logic [31:0] RD1, RD2, WD;
    logic        use_rs1, use_rs2, RegWrite, issue, issue_wr, stall;

    int n_cmp = 0;
    int n_err = 0;
    bit go    = 1'b0;

    // Reference state: architectural values and "result pending" flags.
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    regfile_wb dut (
        .clk(clk), .rst(rst), .RS1(RS1), .RS2(RS2), .RD1(RD1), .RD2(RD2),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .RegWrite(RegWrite), .WR(WR),
        .WD(WD), .issue(issue), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (RegWrite && WR == a) return WD;
        return m_reg[a];
    endfunction

    function automatic bit pending(input bit u, input logic [4:0] a);
        return u && a != 0 && m_busy[a] && !(RegWrite && WR == a);
    endfunction

    function automatic bit exp_stall();
        return pending(use_rs1, RS1) || pending(use_rs2, RS2);
    endfunction

    // Model update on the clock edge.
    always @(posedge clk) begin
        bit st;
        st = exp_stall();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
        end else begin
            if (RegWrite && WR != 0) begin m_reg[WR] = WD; m_busy[WR] = 0; end
            if (issue && issue_wr && issue_rd != 0 && !st) m_busy[issue_rd] = 1;
        end
        go = 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (go) begin
            check("model RD1", RD1, exp_rd(RS1));
            check("model RD2", RD2, exp_rd(RS2));
            check("model stall", {31'b0, stall}, {31'b0, exp_stall()});
        end
    end

    task automatic idle();
        rst = 0; RS1 = 0; RS2 = 0; use_rs1 = 0; use_rs2 = 0;
        RegWrite = 0; WR = 0; WD = 0; issue = 0; issue_rd = 0; issue_wr = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle();

        // Reset state across all addresses.
        for (int i = 0; i < 32; i++) begin
            RS1 = 5'(i); RS2 = 5'(31 - i); use_rs1 = 1; use_rs2 = 1; #2;
            check("reset RD1", RD1, 32'h0);
            check("reset RD2", RD2, 32'h0);
            check("reset stall", {31'b0, stall}, 32'h0);
            step();
        end

        // x0 ignores writes, including bypass.
        RegWrite = 1; WR = 0; WD = 32'hDEADBEEF; RS1 = 0; #2;
        check("x0 bypass", RD1, 32'h0);
        step();
        RS1 = 0; #2;
        check("x0 read", RD1, 32'h0);
        step();

        // Write x5 with same-cycle bypass, then read next cycle.
        RegWrite = 1; WR = 5; WD = 32'h12345678; RS1 = 5; #2;
        check("x5 bypass", RD1, 32'h12345678);
        step();
        RS2 = 5; #2;
        check("x5 read", RD2, 32'h12345678);
        step();

        // Issue rd=7 then dependent read.
        issue = 1; issue_wr = 1; issue_rd = 7;
        step();
        RS1 = 7; use_rs1 = 1; #2;
        check("x7 stall", {31'b0, stall}, 32'h1);
        use_rs1 = 0; #1;
        check("x7 unused", {31'b0, stall}, 32'h0);
        use_rs1 = 1; RegWrite = 1; WR = 7; WD = 32'hA5; #1;
        check("x7 wb stall", {31'b0, stall}, 32'h0);
        check("x7 wb RD1", RD1, 32'hA5);
        step();
        RS1 = 7; use_rs1 = 1; #2;
        check("x7 cleared", {31'b0, stall}, 32'h0);
        check("x7 value", RD1, 32'hA5);
        step();

        // Same-edge issue and write-back to x9: set wins.
        issue = 1; issue_wr = 1; issue_rd = 9; RegWrite = 1; WR = 9; WD = 32'h1;
        step();
        RS2 = 9; use_rs2 = 1; #2;
        check("x9 busy", {31'b0, stall}, 32'h1);
        check("x9 value", RD2, 32'h1);
        step();
        RegWrite = 1; WR = 9; WD = 32'h2;
        step();

        // Reset while x3 busy and a write-back to x3 arrives.
        RegWrite = 1; WR = 3; WD = 32'h55;
        step();
        issue = 1; issue_wr = 1; issue_rd = 3;
        step();
        RS1 = 3; use_rs1 = 1; #2;
        check("x3 busy", {31'b0, stall}, 32'h1);
        check("x3 value", RD1, 32'h55);
        step();
        rst = 1; RegWrite = 1; WR = 3; WD = 32'h77;
        step();
        RS1 = 3; use_rs1 = 1; #2;
        check("x3 after rst", RD1, 32'h0);
        check("x3 stall after rst", {31'b0, stall}, 32'h0);
        step();
        RS1 = 5; #2;
        check("x5 after rst", RD1, 32'h0);
        step();

        // Issue during stall is dropped.
        issue = 1; issue_wr = 1; issue_rd = 10;
        step();
        RS1 = 10; use_rs1 = 1; issue = 1; issue_wr = 1; issue_rd = 4; #2;
        check("x10 stall", {31'b0, stall}, 32'h1);
        step();
        RS1 = 4; use_rs1 = 1; #2;
        check("x4 not busy", {31'b0, stall}, 32'h0);
        step();

        // Issue without issue_wr sets nothing; issue to x0 sets nothing.
        issue = 1; issue_wr = 0; issue_rd = 11;
        step();
        issue = 1; issue_wr = 1; issue_rd = 0;
        step();
        RS1 = 11; use_rs1 = 1; RS2 = 0; use_rs2 = 1; #2;
        check("x11/x0 no stall", {31'b0, stall}, 32'h0);
        step();
        // Port 2 hazard on x10 still pending.
        RS2 = 10; use_rs2 = 1; #2;
        check("x10 port2 stall", {31'b0, stall}, 32'h1);
        step();

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
